vector_reservation_station: RTL and testbench

- Per-unit reservation station between vector dispatch and one vector execution unit (MADD, CMP, LS, PLS or PERMUTE).
- Buffers dispatched Vector::Vector_operation + Vector::Operands, listens to the result broadcast bus for missing sources and the VCR, and issues the oldest ready entry into a registered output slot feeding the unit.
- Returns the allocated entry index so dispatch can build Vector::Rs_ref tags for dependent operations.

---
 rtl/vector_reservation_station_pkg.sv | 57 +++++
 rtl/vector_reservation_station_age_matrix.sv | 54 +++++
 rtl/vector_reservation_station.sv | 155 +++++++++++++++
 tb/tb_vector_reservation_station.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_reservation_station_pkg.sv
// Shared vector types for the reservation station slice: unit ids, producer tags,
// operation/operand records, station entry record and the operand readiness helpers.
package vector_reservation_station_pkg;

    typedef enum logic [2:0] {
        VU_ID_MADD    = 3'd0,
        VU_ID_CMP     = 3'd1,
        VU_ID_LS      = 3'd2,
        VU_ID_PLS     = 3'd3,
        VU_ID_PERMUTE = 3'd4
    } Unit_id;

    typedef struct packed {
        Unit_id     unit;
        logic [3:0] entry;
    } Rs_ref;

    typedef struct packed {
        logic [7:0] opcode;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
    } Vector_operation;

    typedef struct packed {
        logic [1:0]  required;
        logic [1:0]  valid;
        Rs_ref [1:0] src_ref;
        logic        require_vcr;
        logic        vcr_valid;
    } Operands;

    typedef struct packed {
        Vector_operation op;
        Operands         opnds;
        logic            valid;
    } Rs_entry;

    localparam int unsigned RS_MAX_ENTRIES = 16;

    function automatic logic operands_ready(input Operands o);
        return (&(o.valid | ~o.required)) && (!o.require_vcr || o.vcr_valid);
    endfunction

    // Applies one cycle of result-bus and VCR wakeup to an operand record.
    function automatic Operands operands_wakeup(input Operands o, input logic rv,
                                                input Rs_ref rr, input logic vw);
        Operands r;
        r = o;
        for (int unsigned i = 0; i < 2; i++) begin
            if (rv && r.required[i] && !r.valid[i] && (r.src_ref[i] == rr)) r.valid[i] = 1'b1;
        end
        if (vw && r.require_vcr) r.vcr_valid = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/vector_reservation_station_age_matrix.sv
// Age matrix for the reservation station: tracks relative entry age and grants the
// oldest requesting entry (one-hot).
module vector_rs_age_matrix #(
    parameter int unsigned NUM_ENTRIES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   alloc_en,
    input  logic [3:0]             alloc_idx,
    input  logic                   free_en,
    input  logic [3:0]             free_idx,
    input  logic [NUM_ENTRIES-1:0] req,
    output logic [NUM_ENTRIES-1:0] grant
);

    // age_q[i][j] set means entry i is older than entry j
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (clear) begin
            age_d = '0;
        end else begin
            for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
                if (free_en && (free_idx == 4'(j))) begin
                    for (int unsigned i = 0; i < NUM_ENTRIES; i++) age_d[i][j] = 1'b0;
                end
                if (alloc_en && (alloc_idx == 4'(j))) begin
                    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                        age_d[i][j] = (i != j);
                        age_d[j][i] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            grant[i] = req[i];
            for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
                if ((j != i) && req[j] && age_q[j][i]) grant[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) age_q <= '0;
        else       age_q <= age_d;
    end

endmodule

// File: rtl/vector_reservation_station.sv
// Vector reservation station: buffers dispatched ops, wakes sources from the result bus
// and VCR, issues the oldest ready entry to a registered slot. Option: VECTOR_RS_DISPATCH_BYPASS_EN.
module vector_reservation_station
    import vector_reservation_station_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter Unit_id      UNIT_ID     = VU_ID_MADD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  Vector_operation in_op,
    input  Operands         in_operands,
    output logic [3:0]      in_entry,
    input  logic            res_valid,
    input  Rs_ref           res_ref,
    input  logic            vcr_wb,
    output logic            out_valid,
    input  logic            out_ready,
    output Vector_operation out_op,
    output Operands         out_operands,
    output Rs_ref           out_ref,
    output logic [4:0]      count
);

    Rs_entry         entries_q [NUM_ENTRIES];
    Rs_entry         entries_d [NUM_ENTRIES];
    logic [4:0]      count_q, count_d;
    logic            out_valid_q, out_valid_d;
    Vector_operation out_op_q, out_op_d;
    Operands         out_operands_q, out_operands_d;
    Rs_ref           out_ref_q, out_ref_d;

    logic [NUM_ENTRIES-1:0] ready, grant;
    logic [3:0]             issue_idx;
    Rs_entry                issue_entry;
    Operands                in_woken;
    logic                   accept, load, bypass, alloc;

    always_comb begin
        in_ready = (count_q != 5'(NUM_ENTRIES));
        in_entry = '0;
        for (int unsigned e = NUM_ENTRIES; e > 0; e--) begin
            if (!entries_q[e-1].valid) in_entry = 4'(e - 1);
        end
    end

    always_comb begin
        ready       = '0;
        issue_idx   = '0;
        issue_entry = '0;
        for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
            ready[e] = entries_q[e].valid && operands_ready(entries_q[e].opnds);
            if (grant[e]) begin
                issue_idx   = 4'(e);
                issue_entry = entries_q[e];
            end
        end
    end

    always_comb begin
        in_woken = operands_wakeup(in_operands, res_valid, res_ref, vcr_wb);
        accept   = in_valid && in_ready;
        load     = (!out_valid_q || out_ready) && (|ready);
`ifdef VECTOR_RS_DISPATCH_BYPASS_EN
        bypass   = (!out_valid_q || out_ready) && !(|ready) && accept && operands_ready(in_woken);
`else
        bypass   = 1'b0;
`endif
        alloc    = accept && !bypass;
    end

    vector_rs_age_matrix #(.NUM_ENTRIES(NUM_ENTRIES)) u_age (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .alloc_en  (alloc),
        .alloc_idx (in_entry),
        .free_en   (load),
        .free_idx  (issue_idx),
        .req       (ready),
        .grant     (grant)
    );

    always_comb begin
        for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
            entries_d[e] = entries_q[e];
            if (entries_q[e].valid)
                entries_d[e].opnds = operands_wakeup(entries_q[e].opnds, res_valid, res_ref, vcr_wb);
            if (load && grant[e]) entries_d[e].valid = 1'b0;
            if (alloc && (in_entry == 4'(e))) entries_d[e] = '{op: in_op, opnds: in_woken, valid: 1'b1};
            if (flush) entries_d[e].valid = 1'b0;
        end
        count_d = flush ? '0 : (count_q + 5'(alloc) - 5'(load));
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_op_d       = out_op_q;
        out_operands_d = out_operands_q;
        out_ref_d      = out_ref_q;
        if (flush) begin
            out_valid_d    = 1'b0;
            out_op_d       = '0;
            out_operands_d = '0;
            out_ref_d      = '0;
        end else if (load) begin
            out_valid_d    = 1'b1;
            out_op_d       = issue_entry.op;
            out_operands_d = issue_entry.opnds;
            out_ref_d      = '{unit: UNIT_ID, entry: issue_idx};
        end else if (bypass) begin
            out_valid_d    = 1'b1;
            out_op_d       = in_op;
            out_operands_d = in_woken;
            out_ref_d      = '{unit: UNIT_ID, entry: in_entry};
        end else if (out_ready) begin
            out_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned e = 0; e < NUM_ENTRIES; e++) entries_q[e] <= '0;
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_op_q       <= '0;
            out_operands_q <= '0;
            out_ref_q      <= '0;
        end else begin
            entries_q      <= entries_d;
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_op_q       <= out_op_d;
            out_operands_q <= out_operands_d;
            out_ref_q      <= out_ref_d;
        end
    end

    assign count        = count_q;
    assign out_valid    = out_valid_q;
    assign out_op       = out_op_q;
    assign out_operands = out_operands_q;
    assign out_ref      = out_ref_q;

    a_no_accept_when_full: assert property (@(posedge clk) disable iff (reset)
        !(in_valid && !in_ready && alloc));
    a_full_holds_count: assert property (@(posedge clk) disable iff (reset)
        (in_valid && !in_ready && !flush && !load) |=> (count_q == $past(count_q)));
    a_issued_operands_valid: assert property (@(posedge clk) disable iff (reset)
        !(out_valid_q && (|(out_operands_q.required & ~out_operands_q.valid))));

endmodule

// File: tb/tb_vector_reservation_station.sv
// Directed bench for vector_reservation_station: expected issues are queued at dispatch or
// wakeup time and compared (op, operands, tag, cycle) when the output slot hands off.
module tb_vector_reservation_station;
    import vector_reservation_station_pkg::*;

    localparam Unit_id TB_UNIT = VU_ID_MADD;
`ifdef VECTOR_RS_DISPATCH_BYPASS_EN
    localparam int         LAT   = 1;
    localparam logic [3:0] T1_E1 = 4'd0;
    localparam logic [3:0] T1_E2 = 4'd0;
    localparam int         T4_CNT = 4;
`else
    localparam int         LAT   = 2;
    localparam logic [3:0] T1_E1 = 4'd1;
    localparam logic [3:0] T1_E2 = 4'd0;   // entry 0 is freed when it loads the slot
    localparam int         T4_CNT = 5;
`endif

    logic clk = 1'b0;
    logic reset, flush, in_valid, in_ready, res_valid, vcr_wb, out_valid, out_ready;
    Vector_operation in_op, out_op;
    Operands in_operands, out_operands;
    Rs_ref res_ref, out_ref;
    logic [3:0] in_entry;
    logic [4:0] count;

    typedef struct {
        Vector_operation op;
        Operands         opnds;
        logic [3:0]      entry;
        int              cyc;
    } sb_item_t;
    sb_item_t sb [$];
    sb_item_t it;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0, b;

    vector_reservation_station #(.NUM_ENTRIES(8), .UNIT_ID(TB_UNIT)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_operands(in_operands), .in_entry(in_entry), .res_valid(res_valid),
        .res_ref(res_ref), .vcr_wb(vcr_wb), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_operands(out_operands), .out_ref(out_ref), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic Vector_operation mk_op(input logic [7:0] tag);
        Vector_operation o;
        o = '{opcode: tag, vd: tag[4:0], vs1: 5'd1, vs2: 5'd2};
        return o;
    endfunction

    function automatic Rs_ref mk_ref(input Unit_id u, input int e);
        Rs_ref r;
        r = '{unit: u, entry: 4'(e)};
        return r;
    endfunction

    function automatic Operands opnds_ready();
        Operands o;
        o = '0;
        o.required = 2'b11;
        o.valid    = 2'b11;
        return o;
    endfunction

    function automatic Operands opnds_wait(input int slot, input Rs_ref r);
        Operands o;
        o = '0;
        o.required[slot] = 1'b1;
        o.src_ref[slot]  = r;
        return o;
    endfunction

    function automatic Operands woken(input Operands o);
        Operands w;
        w = o;
        w.valid = o.required;
        return w;
    endfunction

    task automatic drive(input Vector_operation op, input Operands o);
        in_valid    = 1'b1;
        in_op       = op;
        in_operands = o;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        in_op       = '0;
        in_operands = '0;
    endtask

    task automatic push(input Vector_operation op, input Operands o, input logic [3:0] e, input int c);
        sb_item_t s;
        s.op = op; s.opnds = o; s.entry = e; s.cyc = c;
        sb.push_back(s);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk(tag, 64'(sb.size()), 64'(0));
    endtask

    task automatic chk_cleared(input string pfx);
        chk({pfx, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({pfx, "_count"},     64'(count),     64'(0));
        chk({pfx, "_in_ready"},  64'(in_ready),  64'(1));
        chk({pfx, "_in_entry"},  64'(in_entry),  64'(0));
        chk({pfx, "_out_op"},    64'(out_op),    64'(0));
        chk({pfx, "_out_ref"},   64'(out_ref),   64'(0));
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_issue observed op=%0h expected no issue", out_op);
            end else begin
                it = sb.pop_front();
                chk("issue_op",    64'(out_op),       64'(it.op));
                chk("issue_opnds", 64'(out_operands), 64'(it.opnds));
                chk("issue_ref",   64'(out_ref),      64'({TB_UNIT, it.entry}));
                if (it.cyc >= 0) chk("issue_cycle", 64'(cyc), 64'(it.cyc));
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; res_valid = 1'b0; res_ref = '0; vcr_wb = 1'b0; out_ready = 1'b0;
        idle();
        tick(); tick();
        reset = 1'b0;
        chk_cleared("reset");

        // Three ready ops back to back
        out_ready = 1'b1;
        t0 = cyc;
        drive(mk_op(8'h11), opnds_ready()); chk("t1_entry_a", 64'(in_entry), 64'(0));
        push(mk_op(8'h11), opnds_ready(), 4'd0, t0 + LAT);
        tick();
        drive(mk_op(8'h12), opnds_ready()); chk("t1_entry_b", 64'(in_entry), 64'(T1_E1));
        push(mk_op(8'h12), opnds_ready(), T1_E1, t0 + 1 + LAT);
        tick();
        drive(mk_op(8'h13), opnds_ready()); chk("t1_entry_c", 64'(in_entry), 64'(T1_E2));
        push(mk_op(8'h13), opnds_ready(), T1_E2, t0 + 2 + LAT);
        tick(); idle();
        drain("t1_drain");
        chk("t1_count", 64'(count), 64'(0));

        // Source wakeup; a broadcast from the wrong unit must not wake
        drive(mk_op(8'h21), '{required: 2'b11, valid: 2'b01,
                              src_ref: {mk_ref(VU_ID_CMP, 3), mk_ref(VU_ID_MADD, 0)},
                              require_vcr: 1'b0, vcr_valid: 1'b0});
        chk("t2_entry", 64'(in_entry), 64'(0));
        tick(); idle();
        res_valid = 1'b1; res_ref = mk_ref(VU_ID_LS, 3);
        tick(); res_valid = 1'b0;
        tick(); tick();
        chk("t2_no_wake_valid", 64'(out_valid), 64'(0));
        chk("t2_no_wake_count", 64'(count), 64'(1));
        b = cyc;
        res_valid = 1'b1; res_ref = mk_ref(VU_ID_CMP, 3);
        push(mk_op(8'h21), '{required: 2'b11, valid: 2'b11,
                             src_ref: {mk_ref(VU_ID_CMP, 3), mk_ref(VU_ID_MADD, 0)},
                             require_vcr: 1'b0, vcr_valid: 1'b0}, 4'd0, b + 2);
        tick(); res_valid = 1'b0;
        drain("t2_drain");
        chk("t2_count", 64'(count), 64'(0));

        // Fill every entry with unready ops
        for (int k = 0; k < 8; k++) begin
            drive(mk_op(8'(8'h30 + k)), opnds_wait(1, mk_ref(VU_ID_PLS, k)));
            chk($sformatf("t3_fill_entry%0d", k), 64'(in_entry), 64'(k));
            tick();
        end
        drive(mk_op(8'h3F), opnds_ready());
        chk("t3_full_ready", 64'(in_ready), 64'(0));
        chk("t3_full_count", 64'(count), 64'(8));
        chk("t3_full_entry", 64'(in_entry), 64'(0));
        tick(); idle();
        chk("t3_reject_count", 64'(count), 64'(8));
        chk("t3_reject_entry", 64'(in_entry), 64'(0));
        res_valid = 1'b1; res_ref = mk_ref(VU_ID_PLS, 2);
        b = cyc;
        push(mk_op(8'h32), woken(opnds_wait(1, mk_ref(VU_ID_PLS, 2))), 4'd2, b + 2);
        chk("t3_wake_ready0", 64'(in_ready), 64'(0));
        tick(); res_valid = 1'b0;
        chk("t3_wake_ready1", 64'(in_ready), 64'(0));
        tick();
        chk("t3_wake_ready2", 64'(in_ready), 64'(1));
        chk("t3_wake_count", 64'(count), 64'(7));
        chk("t3_wake_entry", 64'(in_entry), 64'(2));
        tick();

        // Entry 2 refilled younger than entry 5; both wait on the same tag
        drive(mk_op(8'h40), opnds_wait(0, mk_ref(VU_ID_PLS, 5)));
        chk("t4_young_entry", 64'(in_entry), 64'(2));
        out_ready = 1'b0;
        tick(); idle();
        res_valid = 1'b1; res_ref = mk_ref(VU_ID_PLS, 5);
        push(mk_op(8'h35), woken(opnds_wait(1, mk_ref(VU_ID_PLS, 5))), 4'd5, -1);
        push(mk_op(8'h40), woken(opnds_wait(0, mk_ref(VU_ID_PLS, 5))), 4'd2, -1);
        tick(); res_valid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("t4_hold_valid", 64'(out_valid), 64'(1));
            chk("t4_hold_op", 64'(out_op), 64'(mk_op(8'h35)));
            chk("t4_hold_ref", 64'(out_ref), 64'(mk_ref(TB_UNIT, 5)));
            tick();
        end
        out_ready = 1'b1;
        res_valid = 1'b1; res_ref = mk_ref(VU_ID_PLS, 6);
        push(mk_op(8'h36), woken(opnds_wait(1, mk_ref(VU_ID_PLS, 6))), 4'd6, -1);
        tick();
        res_ref = mk_ref(VU_ID_PLS, 7);
        push(mk_op(8'h37), woken(opnds_wait(1, mk_ref(VU_ID_PLS, 7))), 4'd7, -1);
        tick(); res_valid = 1'b0;
        drain("t4_drain");
        chk("t4_count", 64'(count), 64'(4));

        // Broadcast coincident with dispatch of its consumer
        t0 = cyc;
        drive(mk_op(8'h50), opnds_wait(0, mk_ref(VU_ID_CMP, 7)));
        res_valid = 1'b1; res_ref = mk_ref(VU_ID_CMP, 7);
        chk("t5_entry", 64'(in_entry), 64'(2));
        push(mk_op(8'h50), woken(opnds_wait(0, mk_ref(VU_ID_CMP, 7))), 4'd2, t0 + LAT);
        tick(); idle(); res_valid = 1'b0;
        chk("t5_count_next", 64'(count), 64'(T4_CNT));
        drain("t5_drain");
        chk("t5_count", 64'(count), 64'(4));

        // Flush with four entries and a held output; same-cycle dispatch dropped
        out_ready = 1'b0;
        drive(mk_op(8'h60), opnds_ready());
        tick(); idle();
        tick(); tick();
        chk("t6_held", 64'(out_valid), 64'(1));
        drive(mk_op(8'h61), opnds_ready());
        flush = 1'b1;
        tick(); flush = 1'b0; idle();
        chk_cleared("flush");
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t6_after_valid", 64'(out_valid), 64'(0));
        chk("t6_after_count", 64'(count), 64'(0));

        // Reset mid-stream
        out_ready = 1'b0;
        drive(mk_op(8'h70), opnds_wait(1, mk_ref(VU_ID_PLS, 0))); tick();
        drive(mk_op(8'h71), opnds_wait(1, mk_ref(VU_ID_PLS, 1))); tick();
        drive(mk_op(8'h72), opnds_ready()); tick(); idle();
        tick(); tick();
        chk("t7_held", 64'(out_valid), 64'(1));
        chk("t7_count", 64'(count), 64'(2));
        reset = 1'b1;
        drive(mk_op(8'h73), opnds_ready());
        tick(); reset = 1'b0; idle();
        chk_cleared("midreset");
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t7_after_valid", 64'(out_valid), 64'(0));
        chk("t7_after_count", 64'(count), 64'(0));
        chk("final_queue", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
